// File: rtl/platform_pkg.sv
// Shared types and default widths for the Wishbone burst reader.
package platform_pkg;

  localparam int WBR_ADDR_WIDTH     = 32;
  localparam int WBR_DATA_WIDTH     = 32;
  localparam int WBR_LEN_WIDTH      = 16;
  localparam int WBR_FIFO_DEPTH_POT = 4;
  localparam int WBR_TIMEOUT_POT    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_reader_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head; flush and reset empty it.
// Push while full succeeds only together with a pop.
module sync_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH_POT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      pop_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic [FIFO_DEPTH_POT:0]   count_o,
  output logic                      empty_o
);
  localparam int DEPTH = 1 << FIFO_DEPTH_POT;

  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
  logic [FIFO_DEPTH_POT-1:0] r_wr;
  logic [FIFO_DEPTH_POT-1:0] r_rd;
  logic [FIFO_DEPTH_POT:0]   r_cnt;
  logic                      w_pop;
  logic                      w_push;

  assign w_pop  = pop_i && (r_cnt != '0);
  assign w_push = push_i && ((r_cnt != (FIFO_DEPTH_POT+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rd];
  assign count_o = r_cnt;
  assign empty_o = (r_cnt == '0);

endmodule

// File: rtl/wb_burst_reader.sv
// Pipelined Wishbone B4 burst read initiator delivering data on a valid/ready stream.
// Define WB_READER_TIMEOUT_EN to add the ack watchdog.
module wb_burst_reader
  import platform_pkg::*;
#(
  parameter int ADDR_WIDTH     = WBR_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WBR_DATA_WIDTH,
  parameter int LEN_WIDTH      = WBR_LEN_WIDTH,
  parameter int FIFO_DEPTH_POT = WBR_FIFO_DEPTH_POT,
  parameter int TIMEOUT_POT    = WBR_TIMEOUT_POT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [DATA_WIDTH-1:0]   wb_wdata_o,
  input  logic [DATA_WIDTH-1:0]   wb_rdata_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_stall_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i
);
  localparam int DEPTH = 1 << FIFO_DEPTH_POT;
  localparam int CW    = FIFO_DEPTH_POT + 1;

  wb_reader_state_e      r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [CW-1:0]         r_outstanding;
  logic                  r_err;
  logic                  r_discard;
  logic                  r_abort;

  logic [CW-1:0] w_fifo_count;
  logic [CW:0]   w_inflight;
  logic          w_fifo_empty;
  logic          w_live, w_resp, w_resp_err, w_push, w_pop;
  logic          w_stb, w_accept, w_abort, w_start, w_last, w_timeout, w_flush;

  // Requests only go out while every in-flight word already owns a FIFO slot.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_stb      = (r_state == ISSUE) && (r_remaining != '0) && !r_discard &&
                      (w_inflight < (CW+1)'(DEPTH));
  assign w_accept   = w_stb && !wb_stall_i;
  assign w_last     = w_accept && (r_remaining == LEN_WIDTH'(1));

  assign w_live     = (r_outstanding != '0);
  assign w_resp     = w_live && (wb_ack_i || wb_err_i || wb_rty_i);
  assign w_resp_err = w_live && (wb_err_i || wb_rty_i);
  assign w_push     = w_live && wb_ack_i && !wb_err_i && !wb_rty_i && !r_discard;
  assign w_pop      = valid_o && ready_i;

  assign w_abort    = abort_i && ((r_state == ISSUE) || (r_state == DRAIN));
  assign w_start    = (r_state == IDLE) && start_i && w_fifo_empty;
  assign w_flush    = (r_state == DONE) && r_abort;

`ifdef WB_READER_TIMEOUT_EN
  logic [TIMEOUT_POT-1:0] r_wdog;

  always_ff @(posedge clk_i) begin
    if (rst_i || !w_live || w_resp) r_wdog <= '0;
    else                            r_wdog <= r_wdog + 1'b1;
  end

  assign w_timeout = w_live && !w_resp && (r_wdog == '1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_POT;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = (len_i == '0) ? DONE : ISSUE;
      ISSUE: begin
        if (w_timeout) w_next = DONE;
        else if (w_resp_err || w_abort || w_last || (r_remaining == '0)) w_next = DRAIN;
      end
      DRAIN:   if (w_timeout || !w_live) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_discard     <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr      <= base_addr_i;
        r_remaining <= len_i;
        r_err       <= 1'b0;
        r_discard   <= 1'b0;
        r_abort     <= 1'b0;
      end else begin
        if (w_accept) begin
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        if (w_resp_err || w_abort || w_timeout) begin
          r_err     <= 1'b1;
          r_discard <= 1'b1;
        end
        if (w_abort) r_abort <= 1'b1;
      end
      if (w_timeout) r_outstanding <= '0;
      else begin
        case ({w_accept, w_resp})
          2'b10:   r_outstanding <= r_outstanding + 1'b1;
          2'b01:   r_outstanding <= r_outstanding - 1'b1;
          default: r_outstanding <= r_outstanding;
        endcase
      end
    end
  end

  sync_fifo #(
    .DATA_WIDTH     (DATA_WIDTH),
    .FIFO_DEPTH_POT (FIFO_DEPTH_POT)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (w_flush),
    .push_i  (w_push),
    .wdata_i (wb_rdata_i),
    .pop_i   (w_pop),
    .rdata_o (data_o),
    .count_o (w_fifo_count),
    .empty_o (w_fifo_empty)
  );

  assign valid_o    = !w_fifo_empty;
  assign busy_o     = (r_state != IDLE);
  assign done_o     = (r_state == DONE);
  assign err_o      = r_err;
  assign wb_cyc_o   = (r_state == ISSUE) || ((r_state == DRAIN) && w_live);
  assign wb_stb_o   = w_stb;
  assign wb_we_o    = 1'b0;
  assign wb_addr_o  = r_addr;
  assign wb_sel_o   = '1;
  assign wb_wdata_o = '0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Randomized bench for wb_burst_reader: responder, stream sink and a queue-based reference model.
module tb_wb_burst_reader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_addr_o, wb_wdata_o, data_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_rdata_i = '0;
  logic        wb_ack_i = 1'b0, wb_stall_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;

  wb_burst_reader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o), .wb_wdata_o(wb_wdata_o),
    .wb_rdata_i(wb_rdata_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pq[$];      // requests accepted by the bus, awaiting a response
  logic [31:0] mq[$];      // words the stream must still deliver, in order
  logic [31:0] acc_log[$];
  int          n_vec = 0, n_fail = 0;
  int          cyc_n = 0, n_done = 0, n_beats = 0, resp_cnt = 0;
  int          ready_mode = 1, lat = 1, err_at = 0;
  bit          stall_rand = 0, silent = 0;
  bit          m_err = 0, m_disc = 0, m_abort = 0, prev_done = 0;
  logic [31:0] exp_next = '0;
  int          exp_left = 0;

  function automatic logic [31:0] hv(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare/responder process: checks the DUT against the model, then
  // chooses bus/stream inputs for the next edge and advances the model.
  always @(negedge clk) begin
    int    n_mq0;
    pend_t p;
    cyc_n++;
    if (rst_i) begin
      pq.delete(); mq.delete();
      m_err = 0; m_disc = 0; m_abort = 0; prev_done = 0; exp_left = 0;
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0; ready_i = 0;
    end else begin
      if (done_o) begin
        n_done++;
        chk("done_single_cycle", prev_done, 0);
        if (pq.size() != 0) begin  // watchdog abandoned the pending requests
          pq.delete(); m_err = 1; m_disc = 1;
        end
      end
      prev_done = done_o;
      n_mq0 = mq.size();

      chk("valid", valid_o, n_mq0 != 0);
      if (valid_o && n_mq0 != 0) chk("data", data_o, mq[0]);
      chk("err_flag", err_o, m_err);
      if (pq.size() != 0) chk("cyc_held", wb_cyc_o, 1);
      if (!busy_o) chk("idle_bus", {wb_cyc_o, wb_stb_o}, 0);
      if (wb_stb_o) begin
        chk("credit", (pq.size() + n_mq0) < 16, 1);
        chk("stb_after_err", m_disc, 0);
      end

      wb_stall_i = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      ready_i    = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;

      if (valid_o && ready_i && mq.size() != 0) begin
        void'(mq.pop_front());
        n_beats++;
      end

      if (!silent && pq.size() != 0 && pq[0].due <= cyc_n) begin
        p = pq.pop_front();
        resp_cnt++;
        if (resp_cnt == err_at) begin
          wb_err_i = 1; wb_rdata_i = 32'hDEAD_BEEF;
          m_err = 1; m_disc = 1;
        end else begin
          wb_ack_i = 1; wb_rdata_i = hv(p.addr);
          if (!m_disc) mq.push_back(hv(p.addr));
        end
      end

      if (wb_stb_o && !wb_stall_i) begin
        chk("issue_budget", exp_left != 0, 1);
        chk("addr", wb_addr_o, exp_next);
        acc_log.push_back(wb_addr_o);
        pq.push_back('{addr: wb_addr_o, due: cyc_n + lat});
        exp_next = exp_next + 32'd1;
        exp_left--;
      end

      if (abort_i && busy_o && !done_o) begin
        m_err = 1; m_disc = 1; m_abort = 1;
      end

      if (start_i && !busy_o && n_mq0 == 0) begin
        m_err = 0; m_disc = 0; m_abort = 0;
        exp_next = base_addr_i;
        exp_left = int'(len_i);
      end

      if (done_o && m_abort) mq.delete();
    end
  end

  task automatic run_start(input logic [31:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    base_addr_i = b; len_i = l; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string nm);
    for (int i = 0; i < budget && n_done == d0; i++) @(posedge clk);
    chk(nm, n_done != d0, 1);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    for (int i = 0; i < budget && (mq.size() != 0 || valid_o); i++) @(posedge clk);
    chk(nm, mq.size() == 0 && !valid_o, 1);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_addr", wb_addr_o, 0);
    @(posedge clk); #1 rst_i = 0;

    // Basic 8-word burst, 1-cycle ack latency
    n_beats = 0; acc_log.delete(); d0 = n_done;
    run_start(32'h100, 16'd8);
    wait_done(d0, 200, "t1_done");
    wait_drain(100, "t1_drain");
    chk("t1_acc_count", acc_log.size(), 8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++) chk("t1_addr_seq", acc_log[i], 32'h100 + i);
    chk("t1_beats", n_beats, 8);
    chk("t1_done_count", n_done - d0, 1);
    chk("t1_err", err_o, 0);

    // Zero length: no bus cycle, single-cycle busy
    d0 = n_done;
    run_start(32'h55, 16'd0);
    @(negedge clk);
    chk("t2_busy", busy_o, 1);
    chk("t2_done", done_o, 1);
    chk("t2_cyc", wb_cyc_o, 0);
    @(negedge clk);
    chk("t2_busy_after", busy_o, 0);
    chk("t2_done_after", done_o, 0);

    // Back-pressure: credit limit stops requests at 16 in flight
    n_beats = 0; ready_mode = 0; d0 = n_done;
    run_start(32'h4000, 16'd40);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("t3_stb_stopped", wb_stb_o, 0);
    chk("t3_inflight", pq.size() + mq.size(), 16);
    chk("t3_valid", valid_o, 1);
    ready_mode = 1;
    wait_done(d0, 400, "t3_done");
    wait_drain(100, "t3_drain");
    chk("t3_beats", n_beats, 40);

    // Random stall/ready, latency 3, address wrap
    n_beats = 0; acc_log.delete(); stall_rand = 1; lat = 3; ready_mode = 2; d0 = n_done;
    run_start(32'hFFFF_FFF0, 16'd40);
    wait_done(d0, 2000, "t4_done");
    wait_drain(400, "t4_drain");
    chk("t4_acc_count", acc_log.size(), 40);
    if (acc_log.size() == 40) begin
      chk("t4_wrap_zero", acc_log[16], 32'h0);
      chk("t4_last_addr", acc_log[39], 32'h17);
    end
    chk("t4_beats", n_beats, 40);
    chk("t4_err", err_o, 0);

    // Bus error on 5th response with 3 outstanding
    n_beats = 0; acc_log.delete(); stall_rand = 0; lat = 3; ready_mode = 1;
    resp_cnt = 0; err_at = 5; d0 = n_done;
    run_start(32'h800, 16'd20);
    wait_done(d0, 200, "t5_done");
    wait_drain(100, "t5_drain");
    chk("t5_err", err_o, 1);
    chk("t5_beats", n_beats, 4);
    chk("t5_accepts", acc_log.size(), 8);
    chk("t5_responses", resp_cnt, 8);
    chk("t5_done_count", n_done - d0, 1);
    err_at = 0;

    // Abort mid-burst flushes the FIFO at the end
    ready_mode = 0; lat = 2; d0 = n_done;
    run_start(32'h1234, 16'd30);
    repeat (8) @(posedge clk);
    #1 abort_i = 1;
    @(posedge clk); #1 abort_i = 0;
    wait_done(d0, 200, "t6_done");
    @(negedge clk);
    chk("t6_err", err_o, 1);
    chk("t6_flushed", valid_o, 0);
    chk("t6_idle", busy_o, 0);

    // Start ignored while FIFO holds data
    n_beats = 0; lat = 1; d0 = n_done;
    run_start(32'h200, 16'd4);
    wait_done(d0, 100, "t8_done");
    run_start(32'h300, 16'd4);
    @(negedge clk);
    chk("t8_start_ignored", busy_o, 0);
    ready_mode = 1;
    wait_drain(100, "t8_drain");
    chk("t8_beats", n_beats, 4);

    // Silent responder
    silent = 1; d0 = n_done;
    run_start(32'h900, 16'd4);
`ifdef WB_READER_TIMEOUT_EN
    wait_done(d0, 2000, "t7_watchdog_done");
    @(negedge clk);
    chk("t7_watchdog_err", err_o, 1);
    chk("t7_cyc_dropped", wb_cyc_o, 0);
`else
    repeat (1100) @(posedge clk);
    @(negedge clk);
    chk("t7_hang_busy", busy_o, 1);
    chk("t7_hang_cyc", wb_cyc_o, 1);
`endif
    @(posedge clk); #1 rst_i = 1;
    @(posedge clk); #1 rst_i = 0; silent = 0;
    @(negedge clk);
    chk("t7_rst_busy", busy_o, 0);
    chk("t7_rst_cyc", wb_cyc_o, 0);
    chk("t7_rst_valid", valid_o, 0);
    chk("t7_rst_err", err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
